// File: rtl/pipe_ex_pkg.sv
// Purpose : shared constants for the pipe_ex arithmetic pipeline.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   N_DEFAULT  - default operand / result width
//   PIPE_DEPTH - number of register stages between operands and result
package pipe_ex_pkg;

    localparam int N_DEFAULT  = 10;
    localparam int PIPE_DEPTH = 3;

endpackage : pipe_ex_pkg

// File: rtl/pipe_ex_if.sv
// Purpose : operand/result bundle for the pipe_ex datapath.
// Latency : n/a (wires only).
// Backpressure: none; the bundle carries no flow control.
//
// Signals:
//   a, b, c, d  - N-bit operands, driven by the master
//   f           - N-bit registered result, driven by the slave
//   out_valid   - high once f holds a result from post-reset operands
interface pipe_ex_if #(
    parameter int N = pipe_ex_pkg::N_DEFAULT
);

    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [N-1:0] d;
    logic [N-1:0] f;
    logic         out_valid;

    // Master drives operands and observes the result.
    modport master (
        output a,
        output b,
        output c,
        output d,
        input  f,
        input  out_valid
    );

    // Slave (the pipeline) consumes operands and produces the result.
    modport slave (
        input  a,
        input  b,
        input  c,
        input  d,
        output f,
        output out_valid
    );

endinterface : pipe_ex_if

// File: rtl/pipe_ex_core.sv
// Purpose : three-stage pipeline computing f = ((a + b) + (c - d)) * d mod 2^N.
// Latency : operands sampled at edge k appear on f after edge k+2.
// Backpressure: none; accepts one operand set and yields one result every cycle.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears every stage and the valid chain
//   bus    - pipe_ex_if slave: operands in, f / out_valid out
module pipe_ex_core
    import pipe_ex_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    pipe_ex_if.slave  bus
);

    // Stage 1 registers
    logic [N-1:0] x1_q, x1_d;
    logic [N-1:0] x2_q, x2_d;
    logic [N-1:0] d1_q, d1_d;
    // Stage 2 registers
    logic [N-1:0] x3_q, x3_d;
    logic [N-1:0] d2_q, d2_d;
    // Stage 3 register (result)
    logic [N-1:0] f_q,  f_d;

    // Valid chain: one bit per stage, filled with ones after reset so the
    // MSB rises together with the first result built from post-reset operands.
    logic [PIPE_DEPTH-1:0] vld_sr_q, vld_sr_d;

    always_comb begin
        x1_d     = '0;
        x2_d     = '0;
        d1_d     = '0;
        x3_d     = '0;
        d2_d     = '0;
        f_d      = '0;
        vld_sr_d = '0;

        // All arithmetic is N bits wide: sums wrap, the difference wraps in
        // two's complement and the product keeps only its low N bits.
        x1_d     = bus.a + bus.b;
        x2_d     = bus.c - bus.d;
        d1_d     = bus.d;

        x3_d     = x1_q + x2_q;
        d2_d     = d1_q;

        f_d      = x3_q * d2_q;

        vld_sr_d = {vld_sr_q[PIPE_DEPTH-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q     <= '0;
            x2_q     <= '0;
            d1_q     <= '0;
            x3_q     <= '0;
            d2_q     <= '0;
            f_q      <= '0;
            vld_sr_q <= '0;
        end else begin
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            d1_q     <= d1_d;
            x3_q     <= x3_d;
            d2_q     <= d2_d;
            f_q      <= f_d;
            vld_sr_q <= vld_sr_d;
        end
    end

    // Outputs come straight from flops: no combinational input-to-output path.
    assign bus.f         = f_q;
    assign bus.out_valid = vld_sr_q[PIPE_DEPTH-1];

endmodule : pipe_ex_core

// File: rtl/pipe_ex.sv
// Purpose : top of the pipe_ex arithmetic pipeline, F = ((A + B) + (C - D)) * D mod 2^N.
// Latency : 3 edges counting the sampling edge (sampled at edge k, on F after edge k+2).
// Backpressure: none; one result per cycle, no stall.
//
// Ports (positional order is part of the contract):
//   F          - N-bit registered result
//   A, B, C, D - N-bit unsigned operands (D is also the multiplier)
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   out_valid  - high once F holds a result derived from post-reset inputs
module pipe_ex
    import pipe_ex_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    output logic [N-1:0] F,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    input  logic         clk,
    input  logic         rst_n,
    output logic         out_valid
);

    // The flat port list is kept for existing positional users; internally
    // the datapath is reached through the operand/result bundle.
    pipe_ex_if #(.N(N)) bus ();

    assign bus.a     = A;
    assign bus.b     = B;
    assign bus.c     = C;
    assign bus.d     = D;
    assign F         = bus.f;
    assign out_valid = bus.out_valid;

    pipe_ex_core #(
        .N (N)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

endmodule : pipe_ex

// File: tb/tb_pipe_ex.sv
// Purpose : self-checking bench for pipe_ex against a plain-arithmetic reference.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pipe_ex;

    localparam int W = 10;

    logic clk;
    logic rst_n;

    pipe_ex_if #(.N(W)) tb_bus ();

    pipe_ex #(.N(W)) dut (
        .F         (tb_bus.f),
        .A         (tb_bus.a),
        .B         (tb_bus.b),
        .C         (tb_bus.c),
        .D         (tb_bus.d),
        .clk       (clk),
        .rst_n     (rst_n),
        .out_valid (tb_bus.out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected F after each coming edge, oldest first.
    logic [W-1:0] exp_q[$];
    int           edges_since_rst;

    // Reference: integer arithmetic, then reduced modulo 2^W.
    function automatic logic [W-1:0] model(input int a, input int b, input int c, input int d);
        int r;
        r = ((a + b) + (c - d)) * d;
        r = r % 1024;
        if (r < 0) r = r + 1024;
        return r[W-1:0];
    endfunction

    // After release the first two edges still flush zeros; the third edge
    // shows the operands present at the first edge (the ones held right now).
    task automatic release_reset();
        rst_n = 1'b1;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        exp_q.push_back(model(tb_bus.a, tb_bus.b, tb_bus.c, tb_bus.d));
        edges_since_rst = 0;
    endtask

    // Advance one edge, sample just after it, then apply the next operands.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d,
                        output logic [W-1:0] f_obs, output logic [W-1:0] f_exp,
                        output logic v_obs, output logic v_exp);
        @(posedge clk);
        #1;
        edges_since_rst++;
        f_obs = tb_bus.f;
        v_obs = tb_bus.out_valid;
        f_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        v_exp = (edges_since_rst >= 3);
        tb_bus.a = a;
        tb_bus.b = b;
        tb_bus.c = c;
        tb_bus.d = d;
        exp_q.push_back(model(a, b, c, d));
    endtask

    task automatic test_reset();
        logic [W-1:0] fo, fe;
        logic vo, ve;
        rst_n = 1'b0;
        tb_bus.a = 10'd100; tb_bus.b = 10'd200; tb_bus.c = 10'd300; tb_bus.d = 10'd7;
        #1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (tb_bus.f !== '0 || tb_bus.out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold cyc=%0d F=%0d out_valid=%b required F=0 out_valid=0",
                         i, tb_bus.f, tb_bus.out_valid);
            end
        end
        #2;
        release_reset();
        for (int i = 1; i <= 3; i++) begin
            step(10'd100, 10'd200, 10'd300, 10'd7, fo, fe, vo, ve);
            tests_run++;
            if (vo !== (i == 3) || fo !== fe) begin
                tests_failed++;
                $display("FAIL reset_release edge=%0d F=%0d out_valid=%b required F=%0d out_valid=%b",
                         i, fo, vo, fe, (i == 3));
            end
        end
        // (100+200)+(300-7)=593, *7=4151 mod 1024 = 55
        tests_run++;
        if (fo !== 10'd55) begin
            tests_failed++;
            $display("FAIL reset_first_result F=%0d required 55", fo);
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] va[5] = '{10'd10, 10'd5,  10'd2, 10'd3,  10'd5};
        logic [W-1:0] vb[5] = '{10'd20, 10'd15, 10'd4, 10'd6,  10'd2};
        logic [W-1:0] vc[5] = '{10'd30, 10'd25, 10'd6, 10'd8,  10'd9};
        logic [W-1:0] vd[5] = '{10'd40, 10'd35, 10'd8, 10'd10, 10'd7};
        logic [W-1:0] lit[5] = '{10'd800, 10'd350, 10'd32, 10'd70, 10'd63};
        logic [W-1:0] fo, fe;
        logic vo, ve;
        for (int s = 0; s < 8; s++) begin
            int k;
            k = (s < 5) ? s : 4;
            step(va[k], vb[k], vc[k], vd[k], fo, fe, vo, ve);
            if (s >= 3) begin
                tests_run++;
                if (fo !== lit[s-3] || vo !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stream idx=%0d F=%0d out_valid=%b required F=%0d out_valid=1",
                             s - 3, fo, vo, lit[s-3]);
                end
            end
        end
    endtask

    task automatic test_negative();
        logic [W-1:0] fo, fe;
        logic vo, ve;
        for (int s = 0; s < 4; s++) begin
            step(10'd0, 10'd0, 10'd0, 10'd1, fo, fe, vo, ve);
            if (s == 3) begin
                tests_run++;
                if (fo !== 10'd1023) begin
                    tests_failed++;
                    $display("FAIL negative_wrap F=%0d required 1023", fo);
                end
            end
        end
    endtask

    task automatic test_truncation();
        logic [W-1:0] fo, fe;
        logic vo, ve;
        step(10'd31, 10'd1, 10'd1,  10'd1,  fo, fe, vo, ve);
        step(10'd31, 10'd1, 10'd33, 10'd32, fo, fe, vo, ve);
        step(10'd31, 10'd1, 10'd33, 10'd32, fo, fe, vo, ve);
        step(10'd31, 10'd1, 10'd33, 10'd32, fo, fe, vo, ve);
        tests_run++;
        if (fo !== 10'd32) begin
            tests_failed++;
            $display("FAIL trunc_plain F=%0d required 32", fo);
        end
        step(10'd31, 10'd1, 10'd33, 10'd32, fo, fe, vo, ve);
        tests_run++;
        if (fo !== 10'd32) begin
            tests_failed++;
            $display("FAIL trunc_wrap F=%0d required 32", fo);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] fo, fe;
        logic vo, ve;
        for (int s = 0; s < 200; s++) begin
            step(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                 fo, fe, vo, ve);
            tests_run++;
            if (fo !== fe || vo !== ve) begin
                tests_failed++;
                $display("FAIL random s=%0d F=%0d out_valid=%b required F=%0d out_valid=%b",
                         s, fo, vo, fe, ve);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] fo, fe;
        logic vo, ve;
        step(10'd10, 10'd20, 10'd30, 10'd40, fo, fe, vo, ve);
        step(10'd5,  10'd15, 10'd25, 10'd35, fo, fe, vo, ve);
        step(10'd3,  10'd6,  10'd8,  10'd10, fo, fe, vo, ve);
        // Three results in flight; pulse reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (tb_bus.f !== '0 || tb_bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_clear F=%0d out_valid=%b required F=0 out_valid=0",
                     tb_bus.f, tb_bus.out_valid);
        end
        #1;
        release_reset();
        for (int i = 1; i <= 4; i++) begin
            step(10'd5, 10'd2, 10'd9, 10'd7, fo, fe, vo, ve);
            tests_run++;
            if (fo !== fe || vo !== ve || (i < 3 && fo !== '0)) begin
                tests_failed++;
                $display("FAIL mid_reset_after edge=%0d F=%0d out_valid=%b required F=%0d out_valid=%b",
                         i, fo, vo, fe, ve);
            end
        end
    endtask

    task automatic test_constant();
        logic [W-1:0] fo, fe, f_late;
        logic vo, ve;
        // (700+500)+(100-900)=400, *900=360000 mod 1024 = 576
        for (int s = 0; s < 7; s++) begin
            step(10'd700, 10'd500, 10'd100, 10'd900, fo, fe, vo, ve);
            if (s >= 3) begin
                #7;
                f_late = tb_bus.f;
                tests_run++;
                if (fo !== 10'd576 || f_late !== 10'd576) begin
                    tests_failed++;
                    $display("FAIL constant s=%0d F_after_edge=%0d F_before_edge=%0d required 576",
                             s, fo, f_late);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        edges_since_rst = 0;
        test_reset();
        test_stream();
        test_negative();
        test_truncation();
        test_random();
        test_mid_reset();
        test_constant();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pipe_ex

// File: doc/pipe_ex.md
Name: pipe_ex

Overview:
- Three-stage arithmetic pipeline computing F = ((A + B) + (C − D)) × D on N-bit unsigned operands.
- Accepts a new operand set every clock cycle and produces one result per cycle with fixed 3-cycle latency.
- Used as a small datapath building block and as a pipelining reference block.

Parameters:
- N, 10, width of every operand, every intermediate register and the result.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- F  output  N  pipeline result, registered.
- A  input  N  operand A.
- B  input  N  operand B.
- C  input  N  operand C.
- D  input  N  operand D, also the multiplier.
- out_valid  output  1  high once F holds a result derived from post-reset inputs.
- Positional order is fixed: F, A, B, C, D, clk, rst_n, out_valid. Existing positional instantiations that connect only the first six ports must remain legal.

Behaviour:
- Stage 1, at the clk rising edge:
  - x1 <= A + B
  - x2 <= C − D
  - d1 <= D
- Stage 2, at the clk rising edge:
  - x3 <= x1 + x2
  - d2 <= d1
- Stage 3, at the clk rising edge:
  - F <= x3 × d2
- Latency: operands sampled at edge k appear on F after edge k+2. That is 3 edges counting the sampling edge.
- Throughput: one result per cycle. No stall, no bubble handling, no handshake.
- Arithmetic:
  - All operations are modulo 2^N.
  - Subtraction wraps in two's complement.
  - The product is truncated to its low N bits.
  - No saturation and no overflow flag.
- Reset (rst_n low, asynchronous, independent of clk):
  - x1, x2, x3, d1, d2, F and out_valid all clear to 0 immediately.
  - While reset is held, all registers stay 0.
- Reset mid-operation: all in-flight results are discarded. After rst_n deasserts, the first new result appears on F after the third rising edge.
- out_valid:
  - A 3-bit shift register shifts in 1 on each edge after reset.
  - out_valid is the MSB of that register.
  - It rises coincident with the first F computed from post-reset inputs and stays high until the next reset.
- The outputs are purely registered. There is no combinational path from inputs to F.
- RTL contains no # delays.
- Unknown or X inputs propagate. No special handling is required.

Decomposition:
- Shared package holds:
  - default width constant N_DEFAULT = 10
  - pipeline depth constant PIPE_DEPTH = 3
- Optional sub-module: pipe_stage_reg, an N-bit register with async active-low clear, instantiated for each stage register. Inline always blocks are equally acceptable.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with nonzero inputs -> F = 0 and out_valid = 0 throughout; release and verify out_valid rises exactly at the third edge.
- Streaming sequence: apply one operand set per cycle, changing between edges:
  - (10,20,30,40) -> 800
  - (5,15,25,35) -> 350
  - (2,4,6,8) -> 32
  - (3,6,8,10) -> 70
  - (5,2,9,7) -> 63
  - Each result must appear exactly 3 edges after its inputs were sampled, in the same order, one per cycle.
- Negative intermediate: A=0, B=0, C=0, D=1 -> (0 + 1023) × 1 = 1023.
- Product truncation: A=B=0, C=D... instead use A=31, B=1, C=1, D=1 -> 32 × 1 = 32; then A=31, B=1, C=33, D=32 -> (32 + 1) × 32 = 1056 mod 1024 = 32.
- Mid-stream reset: pulse rst_n low between edges while 3 results are in flight -> F clears immediately, and no stale result appears after release.
- Constant inputs held steady -> F is constant after 3 edges with no glitches at the clock edge.
